// File: rtl/flex_down_counter_pkg.sv
// Shared types and constants for the flex_down_counter timeout/delay generator.
// Optional periodic mode is selected with FLEX_DOWN_COUNTER_AUTO_RELOAD_EN.
package flex_down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int RESET_COUNT = 0;

endpackage

// File: rtl/flex_down_counter_if.sv
// Control/status bundle between a protocol FSM (master) and the down-counter (slave).
interface flex_down_counter_if #(
    parameter int NUM_CNT_BITS = 4
);
    logic                    clear;
    logic                    load;
    logic [NUM_CNT_BITS-1:0] load_val;
    logic                    count_enable;
    logic [NUM_CNT_BITS-1:0] count_out;
    logic                    busy;
    logic                    expired_flag;

    modport master (
        output clear, load, load_val, count_enable,
        input  count_out, busy, expired_flag
    );

    modport slave (
        input  clear, load, load_val, count_enable,
        output count_out, busy, expired_flag
    );
endinterface

// File: rtl/flex_down_counter.sv
// Loadable down-counter with a one-cycle registered expiry pulse on reaching zero.
// Define FLEX_DOWN_COUNTER_AUTO_RELOAD_EN for periodic reload from the last loaded value.
module flex_down_counter
    import flex_down_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    flex_down_counter_if.slave        bus
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_RST = NUM_CNT_BITS'(RESET_COUNT);
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

    state_t                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
    logic                    expired_q, expired_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;

        if (bus.clear) begin
            state_d = IDLE;
            count_d = CNT_RST;
        end else if (bus.load) begin
            // A zero load is a no-op timer: park in IDLE without a pulse.
            reload_d = bus.load_val;
            if (bus.load_val != CNT_RST) begin
                count_d = bus.load_val;
                state_d = COUNT;
            end else begin
                count_d = CNT_RST;
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                COUNT: begin
                    if (bus.count_enable) begin
                        if (count_q > CNT_ONE) begin
                            count_d = count_q - CNT_ONE;
                        end else begin
                            // Terminal step is taken from 1, so the count never wraps.
                            expired_d = 1'b1;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
                            count_d = reload_q;
                            state_d = COUNT;
`else
                            count_d = CNT_RST;
                            state_d = DONE;
`endif
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= CNT_RST;
            reload_q  <= CNT_RST;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

    assign bus.count_out    = count_q;
    assign bus.busy         = (state_q == COUNT);
    assign bus.expired_flag = expired_q;

endmodule

// File: tb/tb_flex_down_counter.sv
// Directed vector bench for flex_down_counter (base or auto-reload build).
module tb_flex_down_counter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    flex_down_counter_if #(.NUM_CNT_BITS(W)) bus ();

    flex_down_counter #(.NUM_CNT_BITS(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         clr;
        logic         ld;
        logic [W-1:0] lv;
        logic         en;
        logic [W-1:0] cnt;
        logic         bsy;
        logic         flg;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic clr, input logic ld, input int lv, input logic en,
                                input int cnt, input logic bsy, input logic flg);
        vec_t v;
        v.clr = clr; v.ld = ld; v.lv = W'(lv); v.en = en;
        v.cnt = W'(cnt); v.bsy = bsy; v.flg = flg;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input int cnt, input int bsy, input int flg);
        chk({name, ".count"}, int'(bus.count_out), cnt);
        chk({name, ".busy"}, int'(bus.busy), bsy);
        chk({name, ".flag"}, int'(bus.expired_flag), flg);
    endtask

    task automatic drive(input logic clr, input logic ld, input int lv, input logic en);
        @(negedge clk);
        bus.clear = clr; bus.load = ld; bus.load_val = W'(lv); bus.count_enable = en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.clear = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.count_enable = 1'b0;

`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
        // Periodic: 3,2,1,3,2,1,3 with a pulse on each reload and busy held.
        add(0, 1, 3, 1, 3, 1, 0);
        add(0, 0, 0, 1, 2, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 3, 1, 1);
        add(0, 0, 0, 1, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 3, 1, 1);
        add(0, 1, 9, 1, 9, 1, 0);
        add(0, 0, 0, 1, 8, 1, 0);
        add(1, 1, 7, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 1, 1, 1);
        add(0, 0, 0, 1, 1, 1, 1);
        add(1, 0, 0, 1, 0, 0, 0);
`else
        // One-shot from 5 with enable held.
        add(0, 1, 5, 1, 5, 1, 0);
        add(0, 0, 0, 1, 4, 1, 0);
        add(0, 0, 0, 1, 3, 1, 0);
        add(0, 0, 0, 1, 2, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        // Enable gaps: 1,0,0,1,1 after loading 3.
        add(0, 1, 3, 0, 3, 1, 0);
        add(0, 0, 0, 1, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // Priority: load beats decrement, clear beats load.
        add(0, 1, 6, 1, 6, 1, 0);
        add(0, 0, 0, 1, 5, 1, 0);
        add(0, 0, 0, 1, 4, 1, 0);
        add(0, 1, 9, 1, 9, 1, 0);
        add(0, 0, 0, 1, 8, 1, 0);
        add(1, 1, 7, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        // Zero load never pulses.
        add(0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0);
        // Shortest count, then a load landing in DONE.
        add(0, 1, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1);
        add(0, 1, 2, 1, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        // Full-scale load value.
        add(0, 1, 15, 0, 15, 1, 0);
        add(0, 0, 0, 1, 14, 1, 0);
        add(0, 0, 0, 0, 14, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0);
`endif

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        chk_all("por", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].ld, int'(vecs[i].lv), vecs[i].en);
            chk_all($sformatf("vec%0d", i), int'(vecs[i].cnt), int'(vecs[i].bsy), int'(vecs[i].flg));
        end

        // Async reset off-edge while counting: outputs clear without waiting for a clock.
        drive(0, 1, 8, 1);
        drive(0, 0, 0, 1);
        chk_all("pre_rst1", 7, 1, 0);
        #2 rst = 1'b1;
        #1 chk_all("rst1_now", 0, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        drive(0, 0, 0, 1);
        chk_all("rst1_after", 0, 0, 0);

        // Reset at count 3 must not be followed by an expiry pulse.
        drive(0, 1, 5, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk_all("pre_rst2", 3, 1, 0);
        #2 rst = 1'b1;
        #1 chk_all("rst2_now", 0, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1);
            chk_all($sformatf("rst2_quiet%0d", k), 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
